// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: queue entry layout, bubble encoding, PC increment.
package fetch_pkg;

   localparam int FETCH_WIDTH = 32;
   localparam logic [FETCH_WIDTH-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   // Contents of instruction-memory word i are IMEM_SEED + i.
   localparam logic [FETCH_WIDTH-1:0] IMEM_SEED = 32'h1000_0000;

   typedef struct packed {
      logic [FETCH_WIDTH-1:0] instr;
      logic [FETCH_WIDTH-1:0] pc;
   } fetch_entry_t;

   function automatic logic [FETCH_WIDTH-1:0] pc_plus4(input logic [FETCH_WIDTH-1:0] pc);
      return pc + FETCH_WIDTH'(4);
   endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-queue boundary: redirect/hazard controls in, IF/ID decode register out.
interface instruction_fetch_queue_if #(
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 4
);
   localparam int COUNT_WIDTH = $clog2(DEPTH) + 1;

   logic                   PCSrcE;
   logic [WORD_WIDTH-1:0]  PCTargetE;
   logic                   StallD;
   logic                   FlushD;
   logic [WORD_WIDTH-1:0]  instrD;
   logic [WORD_WIDTH-1:0]  PCD;
   logic [WORD_WIDTH-1:0]  PCPlus4D;
   logic                   validD;
   logic [COUNT_WIDTH-1:0] ifq_count;

   modport master (
      output PCSrcE, PCTargetE, StallD, FlushD,
      input  instrD, PCD, PCPlus4D, validD, ifq_count
   );

   modport slave (
      input  PCSrcE, PCTargetE, StallD, FlushD,
      output instrD, PCD, PCPlus4D, validD, ifq_count
   );

endinterface

// File: rtl/ifq_fifo.sv
// Generic DEPTH-entry synchronous FIFO with push/pop/flush and combinational head read.
module ifq_fifo #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 64,
   localparam int PTR_WIDTH   = $clog2(DEPTH),
   localparam int COUNT_WIDTH = PTR_WIDTH + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   full,
   output logic                   empty
);

   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   logic [PTR_WIDTH-1:0]   wr_ptr;
   logic [PTR_WIDTH-1:0]   rd_ptr;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   wr_en;
   logic                   rd_en;

   assign full    = (count_q == COUNT_WIDTH'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem[rd_ptr];

   // When full, a write is only legal alongside a read; the head is read before the slot is reused.
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count_q <= count_q + COUNT_WIDTH'(wr_en) - COUNT_WIDTH'(rd_en);
      end
   end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Prefetching instruction fetch stage: PC, internal instruction ROM, DEPTH-entry queue, IF/ID register.
// Define IFQ_BYPASS_EN to let a fetched word skip an empty queue straight into decode.
module instruction_fetch_queue
   import fetch_pkg::*;
#(
   parameter int                    WORD_WIDTH      = FETCH_WIDTH,
   parameter int                    IMEM_ADDR_WIDTH = 8,
   parameter int                    DEPTH           = 4,
   parameter logic [WORD_WIDTH-1:0] RESET_PC        = '0,
   parameter logic [WORD_WIDTH-1:0] NOP_INSTR       = NOP_INSTR_DEFAULT
) (
   input logic                      clk,
   input logic                      reset,
   instruction_fetch_queue_if.slave fq
);

   localparam int IMEM_WORDS  = 2 ** (IMEM_ADDR_WIDTH - 2);
   localparam int COUNT_WIDTH = $clog2(DEPTH) + 1;
   localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

   logic [WORD_WIDTH-1:0]  pc_f;
   logic [WORD_WIDTH-1:0]  imem [IMEM_WORDS];
   logic [WORD_WIDTH-1:0]  fetch_instr;
   fetch_entry_t           fetch_entry;
   fetch_entry_t           head_entry;
   logic [ENTRY_WIDTH-1:0] fifo_rd_data;
   logic [COUNT_WIDTH-1:0] fifo_count;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;
   logic                   push;
   logic                   bypass;
   logic [WORD_WIDTH-1:0]  instr_d;
   logic [WORD_WIDTH-1:0]  pc_d;
   logic [WORD_WIDTH-1:0]  pc_plus4_d;
   logic                   valid_d;

   // Address bits above IMEM_ADDR_WIDTH are not decoded, so the program image aliases.
   for (genvar i = 0; i < IMEM_WORDS; i++) begin : g_imem
      assign imem[i] = IMEM_SEED + WORD_WIDTH'(i);
   end

   assign fetch_instr = imem[pc_f[IMEM_ADDR_WIDTH-1:2]];
   assign fetch_entry = '{instr: fetch_instr, pc: pc_f};
   assign head_entry  = fetch_entry_t'(fifo_rd_data);

   always_comb begin
      bypass = 1'b0;
`ifdef IFQ_BYPASS_EN
      bypass = fifo_empty && !fq.StallD && !fq.FlushD && !fq.PCSrcE;
`endif
      pop  = !fq.StallD && !fq.FlushD && !fq.PCSrcE && !fifo_empty;
      push = !fq.PCSrcE && !bypass && (!fifo_full || pop);
   end

   ifq_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (ENTRY_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .flush   (fq.PCSrcE),
      .wr_data (fetch_entry),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_f <= RESET_PC;
      end else if (fq.PCSrcE) begin
         pc_f <= fq.PCTargetE;
      end else if (push || bypass) begin
         pc_f <= pc_plus4(pc_f);
      end
   end

   // Redirect and FlushD both force a bubble and take precedence over StallD.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_d    <= NOP_INSTR;
         pc_d       <= '0;
         pc_plus4_d <= '0;
         valid_d    <= 1'b0;
      end else if (fq.PCSrcE || fq.FlushD) begin
         instr_d    <= NOP_INSTR;
         pc_d       <= '0;
         pc_plus4_d <= '0;
         valid_d    <= 1'b0;
      end else if (!fq.StallD) begin
         if (pop) begin
            instr_d    <= head_entry.instr;
            pc_d       <= head_entry.pc;
            pc_plus4_d <= pc_plus4(head_entry.pc);
            valid_d    <= 1'b1;
         end else if (bypass) begin
            instr_d    <= fetch_instr;
            pc_d       <= pc_f;
            pc_plus4_d <= pc_plus4(pc_f);
            valid_d    <= 1'b1;
         end else begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
         end
      end
   end

   assign fq.instrD    = instr_d;
   assign fq.PCD       = pc_d;
   assign fq.PCPlus4D  = pc_plus4_d;
   assign fq.validD    = valid_d;
   assign fq.ifq_count = fifo_count;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboard bench for instruction_fetch_queue: queue-based reference model, directed then random stimulus.
module tb_instruction_fetch_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        valid;
      int          count;
      int          step;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   instruction_fetch_queue_if #(.WORD_WIDTH(32), .DEPTH(DEPTH)) ifq_bus ();

   instruction_fetch_queue #(
      .WORD_WIDTH      (32),
      .IMEM_ADDR_WIDTH (8),
      .DEPTH           (DEPTH),
      .RESET_PC        (32'h0000_0000),
      .NOP_INSTR       (NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fq    (ifq_bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: program counter, a queue of fetched PCs and the decode-stage PC.
   logic [31:0] m_pc;
   logic [31:0] m_q[$];
   logic        m_dvalid;
   logic [31:0] m_dpc;
   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          step_no = 0;

   function automatic logic [31:0] rom(input logic [31:0] addr);
      return 32'h1000_0000 + ((addr >> 2) & 32'h0000_003F);
   endfunction

   task automatic modelReset();
      m_pc = 32'h0;
      m_q.delete();
      m_dvalid = 1'b0;
      m_dpc = 32'h0;
   endtask

   task automatic applyStimulus(input logic src, input logic [31:0] tgt,
                                input logic st, input logic fl);
      logic [31:0] fetched;
      logic        can_pop;
      logic        byp;
      exp_t        e;
      ifq_bus.PCSrcE    = src;
      ifq_bus.PCTargetE = tgt;
      ifq_bus.StallD    = st;
      ifq_bus.FlushD    = fl;
      if (src) begin
         m_q.delete();
         m_pc = tgt;
         m_dvalid = 1'b0;
      end else begin
         fetched = m_pc;
         can_pop = !st && !fl && (m_q.size() > 0);
         byp = 1'b0;
`ifdef IFQ_BYPASS_EN
         byp = !st && !fl && (m_q.size() == 0);
`endif
         if (fl) begin
            m_dvalid = 1'b0;
         end else if (!st) begin
            if (can_pop) begin
               m_dpc = m_q.pop_front();
               m_dvalid = 1'b1;
            end else if (byp) begin
               m_dpc = fetched;
               m_dvalid = 1'b1;
            end else begin
               m_dvalid = 1'b0;
            end
         end
         if (byp) begin
            m_pc = m_pc + 32'd4;
         end else if (m_q.size() < DEPTH) begin
            m_q.push_back(fetched);
            m_pc = m_pc + 32'd4;
         end
      end
      e.valid = m_dvalid;
      e.instr = m_dvalid ? rom(m_dpc) : NOP;
      e.pc    = m_dvalid ? m_dpc : 32'h0;
      e.pc4   = m_dvalid ? m_dpc + 32'd4 : 32'h0;
      e.count = m_q.size();
      e.step  = step_no;
      step_no++;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic checkOutput(input exp_t e);
      n_checks++;
      if (ifq_bus.instrD !== e.instr || ifq_bus.PCD !== e.pc || ifq_bus.PCPlus4D !== e.pc4 ||
          ifq_bus.validD !== e.valid || int'(ifq_bus.ifq_count) != e.count) begin
         $display("[TB] FAIL decode_step%0d: got instr=%h pc=%h pc4=%h valid=%b count=%0d, expected instr=%h pc=%h pc4=%h valid=%b count=%0d",
                  e.step, ifq_bus.instrD, ifq_bus.PCD, ifq_bus.PCPlus4D, ifq_bus.validD,
                  ifq_bus.ifq_count, e.instr, e.pc, e.pc4, e.valid, e.count);
      end else begin
         n_pass++;
      end
   endtask

   task automatic checkReset(input string name);
      n_checks++;
      if (ifq_bus.instrD !== NOP || ifq_bus.PCD !== 32'h0 || ifq_bus.PCPlus4D !== 32'h0 ||
          ifq_bus.validD !== 1'b0 || ifq_bus.ifq_count !== '0) begin
         $display("[TB] FAIL %s: got instr=%h pc=%h pc4=%h valid=%b count=%0d, expected instr=%h pc=0 pc4=0 valid=0 count=0",
                  name, ifq_bus.instrD, ifq_bus.PCD, ifq_bus.PCPlus4D, ifq_bus.validD,
                  ifq_bus.ifq_count, NOP);
      end else begin
         n_pass++;
      end
   endtask

   // Monitor: the decode register presents a result after every edge; compare it against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e);
         end
      end
   end

   task automatic randomSteps(input int n);
      logic        src;
      logic [31:0] tgt;
      for (int i = 0; i < n; i++) begin
         src = ($urandom_range(0, 99) < 6);
         tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
         applyStimulus(src, tgt, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 10);
      end
   endtask

   initial begin
      ifq_bus.PCSrcE    = 1'b0;
      ifq_bus.PCTargetE = 32'h0;
      ifq_bus.StallD    = 1'b0;
      ifq_bus.FlushD    = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkReset("reset_state");
      reset = 1'b0;

      // Free run from reset, then a long decode stall that fills the queue, then release.
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

      // Redirect while stalled with three queued entries.
      applyStimulus(1'b1, 32'h0000_0080, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h0000_0040, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

      // Decode flush with a partly filled queue, also overriding a stall.
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

      // PC wrap-around at the top of the address space.
      applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

      randomSteps(400);

      // Asynchronous reset between edges, then restart from the reset PC.
      #2;
      reset = 1'b1;
      #1;
      checkReset("async_reset_immediate");
      @(posedge clk);
      #1;
      checkReset("async_reset_held");
      @(negedge clk);
      reset = 1'b0;
      modelReset();
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

      randomSteps(150);

      #3;
      n_checks++;
      if (exp_q.size() != 0) begin
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end else begin
         n_pass++;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
